// File: rtl/ce_gen_pkg.sv
// ce_gen_pkg
//   Shared constants and types for the multi-channel clock-enable generator.
//   CE_ACC_W_DEF : default accumulator / numerator / denominator width
//   CE_CH_MAX    : largest supported channel count
//   ce_cfg_t     : one ratio setting (num/den) at the default width
//   ce_ch_w()    : width of a channel-select field, never below 1 bit
package ce_gen_pkg;

  localparam int CE_ACC_W_DEF = 16;
  localparam int CE_CH_MAX    = 8;

  typedef struct packed {
    logic [CE_ACC_W_DEF-1:0] num;
    logic [CE_ACC_W_DEF-1:0] den;
  } ce_cfg_t;

  function automatic int ce_ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/ce_gen_chan.sv
// ce_gen_chan
//   One channel of the fractional clock-enable generator: num/den
//   accumulator, double-buffered ratio (shadow pnum/pden + pend flag) and
//   the rule for when the shadow becomes active.
//   Optional feature macro: CE_GEN_PHASE_EN (adds the mid-period ce_n_o).
// Ports
//   clk_sys    : clock
//   reset_n    : asynchronous active-low reset
//   wr_i       : accepted (already validated) write for this channel
//   wr_num_i   : numerator of the write
//   wr_den_i   : denominator of the write
//   pause_i    : hold the accumulator, suppress ticks
//   resync_i   : clear the accumulator, suppress ticks, apply the shadow
//   ce_o       : registered one-cycle enable
//   ce_n_o     : registered half-period enable (CE_GEN_PHASE_EN only)
//   pend_o     : a shadow ratio is waiting to be applied
module ce_gen_chan
  import ce_gen_pkg::*;
#(
  parameter int ACC_W = CE_ACC_W_DEF
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             wr_i,
  input  logic [ACC_W-1:0] wr_num_i,
  input  logic [ACC_W-1:0] wr_den_i,
  input  logic             pause_i,
  input  logic             resync_i,
  output logic             ce_o,
`ifdef CE_GEN_PHASE_EN
  output logic             ce_n_o,
`endif
  output logic             pend_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] num_q, num_d;
  logic [ACC_W-1:0] den_q, den_d;
  logic [ACC_W-1:0] pnum_q, pnum_d;
  logic [ACC_W-1:0] pden_q, pden_d;
  logic             pend_q, pend_d;
  logic             ce_q, ce_d;

  logic [ACC_W:0]   sum;
  logic             enabled;
  logic             step;
  logic             tick;
  logic             apply;

  always_comb begin
    enabled = (num_q != '0);
    // One extra bit so acc + num can never wrap before the compare.
    sum     = {1'b0, acc_q} + {1'b0, num_q};
    step    = enabled && !pause_i && !resync_i;
    tick    = step && (sum >= {1'b0, den_q});
    // The shadow only swaps in at a phase-safe point: on a tick (acc has
    // just wrapped), while idle, or when all phases are being realigned.
    apply   = pend_q && (tick || !enabled || resync_i);

    acc_d = acc_q;
    if (resync_i || !enabled) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = tick ? ACC_W'(sum - {1'b0, den_q}) : ACC_W'(sum);
    end

    num_d = num_q;
    den_d = den_q;
    if (apply) begin
      num_d = pnum_q;
      den_d = pden_q;
    end

    // A write in the same cycle as an apply wins the shadow: the old
    // shadow goes active and the new one stays pending.
    pnum_d = pnum_q;
    pden_d = pden_q;
    pend_d = pend_q;
    if (wr_i) begin
      pnum_d = wr_num_i;
      pden_d = wr_den_i;
      pend_d = 1'b1;
    end else if (apply) begin
      pend_d = 1'b0;
    end

    ce_d = tick;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      num_q  <= '0;
      den_q  <= ACC_W'(1);
      pnum_q <= '0;
      pden_q <= '0;
      pend_q <= 1'b0;
      ce_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      num_q  <= num_d;
      den_q  <= den_d;
      pnum_q <= pnum_d;
      pden_q <= pden_d;
      pend_q <= pend_d;
      ce_q   <= ce_d;
    end
  end

  assign ce_o   = ce_q;
  assign pend_o = pend_q;

`ifdef CE_GEN_PHASE_EN
  logic [ACC_W-1:0] half;
  logic             ce_n_q, ce_n_d;

  // Half-period marker: acc crosses den/2 on a non-tick step. Gated by
  // step, so pause and resync force it low like ce.
  always_comb begin
    half   = den_q >> 1;
    ce_n_d = step && !tick && (acc_q < half) && (sum >= {1'b0, half});
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ce_n_q <= 1'b0;
    end else begin
      ce_n_q <= ce_n_d;
    end
  end

  assign ce_n_o = ce_n_q;
`endif

endmodule

// File: rtl/ce_gen_multi.sv
// ce_gen_multi
//   Multi-channel fractional clock-enable generator. Each channel produces
//   single-cycle enables at num/den of clk_sys with no cumulative drift.
//   Ratios are written through a validated, double-buffered config port.
//   Optional feature macro: CE_GEN_PHASE_EN (adds the ce_n output).
// Ports
//   clk_sys     : clock for all logic
//   reset_n     : asynchronous active-low reset
//   cfg_wr      : one-cycle config write strobe
//   cfg_ch      : target channel of the write
//   cfg_num     : numerator of the write
//   cfg_den     : denominator of the write
//   cfg_err     : one-cycle pulse, write rejected
//   cfg_pending : per channel, shadow ratio waiting to be applied
//   pause       : per-channel freeze
//   resync      : clear all accumulators and apply all shadows
//   ce          : per-channel registered enables
//   ce_n        : per-channel half-period enables (CE_GEN_PHASE_EN only)
module ce_gen_multi
  import ce_gen_pkg::*;
#(
  parameter  int CHANNELS = 3,
  parameter  int ACC_W    = CE_ACC_W_DEF,
  localparam int CH_W     = ce_ch_w(CHANNELS)
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] cfg_pending,
  input  logic [CHANNELS-1:0] pause,
  input  logic                resync,
  output logic [CHANNELS-1:0] ce
`ifdef CE_GEN_PHASE_EN
  ,
  output logic [CHANNELS-1:0] ce_n
`endif
);

  logic ch_ok;
  logic wr_valid;
  logic cfg_err_q, cfg_err_d;

  // cfg_ch can encode more values than there are channels when CHANNELS
  // is not a power of two; those codes are rejected.
  always_comb begin
    ch_ok     = ({1'b0, cfg_ch} < (CH_W + 1)'(CHANNELS));
    wr_valid  = cfg_wr && ch_ok && (cfg_den != '0) && (cfg_num <= cfg_den);
    cfg_err_d = cfg_wr && !wr_valid;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic wr_sel;
      assign wr_sel = wr_valid && (cfg_ch == CH_W'(gi));

      ce_gen_chan #(
        .ACC_W (ACC_W)
      ) u_chan (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .wr_i     (wr_sel),
        .wr_num_i (cfg_num),
        .wr_den_i (cfg_den),
        .pause_i  (pause[gi]),
        .resync_i (resync),
        .ce_o     (ce[gi]),
`ifdef CE_GEN_PHASE_EN
        .ce_n_o   (ce_n[gi]),
`endif
        .pend_o   (cfg_pending[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ce_gen_multi.sv
// tb_ce_gen_multi
//   Directed bench for ce_gen_multi. Expected tick cycles are derived from
//   the ratio (floor(j*num/den) steps) and queued per channel; a monitor
//   compares ce against the queue every cycle.
module tb_ce_gen_multi;

  localparam int CH = 3;
  localparam int AW = 16;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_wr  = 1'b0;
  logic [1:0]    cfg_ch  = '0;
  logic [AW-1:0] cfg_num = '0;
  logic [AW-1:0] cfg_den = '0;
  logic          cfg_err;
  logic [CH-1:0] cfg_pending;
  logic [CH-1:0] pause   = '0;
  logic          resync  = 1'b0;
  logic [CH-1:0] ce;
`ifdef CE_GEN_PHASE_EN
  logic [CH-1:0] ce_n;
`endif

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int hits[CH] = '{default: 0};
  int exp_q[CH][$];
  bit mon_en = 1'b0;

  ce_gen_multi #(
    .CHANNELS (CH),
    .ACC_W    (AW)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_num     (cfg_num),
    .cfg_den     (cfg_den),
    .cfg_err     (cfg_err),
    .cfg_pending (cfg_pending),
    .pause       (pause),
    .resync      (resync),
`ifdef CE_GEN_PHASE_EN
    .ce_n        (ce_n),
`endif
    .ce          (ce)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop the expected tick for this cycle, if any, and compare.
  always @(negedge clk_sys) begin
    if (mon_en) begin
      for (int c = 0; c < CH; c++) begin
        bit e;
        e = (exp_q[c].size() > 0) && (exp_q[c][0] == cyc);
        if (e) void'(exp_q[c].pop_front());
        if (ce[c] === 1'b1) hits[c]++;
        chk($sformatf("ce%0d@%0d", c, cyc), 32'(ce[c]), 32'(e));
      end
    end
  end

  // Push ticks of a channel whose acc is 0 after edge a, running num/den.
  task automatic push_sched(input int c, input int a, input int num, input int den,
                            input int lo, input int hi);
    for (int j = 1; a + j <= hi; j++) begin
      if (((j * num) / den != ((j - 1) * num) / den) && (a + j >= lo))
        exp_q[c].push_back(a + j);
    end
  endtask

  // Returns at the negedge after the sampling edge w.
  task automatic wr(input int ch, input int num, input int den, output int w);
    @(negedge clk_sys);
    cfg_wr  = 1'b1;
    cfg_ch  = 2'(ch);
    cfg_num = AW'(num);
    cfg_den = AW'(den);
    w = cyc + 1;
    @(negedge clk_sys);
    cfg_wr = 1'b0;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk_sys);
  endtask

  // Asynchronous reset mid-stream, then confirm silence afterwards.
  task automatic end_test(input string tag);
    #1 reset_n = 1'b0;
    #1;
    chk({tag, "_rst_ce"}, 32'(ce), 32'(0));
`ifdef CE_GEN_PHASE_EN
    chk({tag, "_rst_ce_n"}, 32'(ce_n), 32'(0));
`endif
    chk({tag, "_rst_pend"}, 32'(cfg_pending), 32'(0));
    for (int c = 0; c < CH; c++)
      chk($sformatf("%s_leftover_ch%0d", tag, c), 32'(exp_q[c].size()), 32'(0));
    repeat (2) @(negedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (20) @(negedge clk_sys);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2, a, a0, a2, r, h;

    repeat (3) @(negedge clk_sys);
    chk("reset_ce", 32'(ce), 32'(0));
    chk("reset_pend", 32'(cfg_pending), 32'(0));
    chk("reset_err", 32'(cfg_err), 32'(0));
`ifdef CE_GEN_PHASE_EN
    chk("reset_ce_n", 32'(ce_n), 32'(0));
`endif
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clk_sys);

    // Divide by 10 on ch0 over 1000 cycles.
    wr(0, 1, 10, w);
    a = w + 1;
    push_sched(0, a, 1, 10, 0, a + 1000);
    chk("div10_pend_set", 32'(cfg_pending), 32'(1));
    h = hits[0];
    wait_to(a);
    chk("div10_pend_clr", 32'(cfg_pending), 32'(0));
    wait_to(a + 1000);
    #1;
    chk("div10_count", 32'(hits[0] - h), 32'(100));
    end_test("div10");

    // Fractional 3/46 on ch1: 300 ticks in 4600 cycles, gaps 15/16.
    wr(1, 3, 46, w);
    a = w + 1;
    push_sched(1, a, 3, 46, 0, a + 4600);
    h = hits[1];
    wait_to(a + 4600);
    #1;
    chk("frac_count", 32'(hits[1] - h), 32'(300));
    end_test("frac");

    // Rejected writes while ch0 runs 1/10, then a live retune to 1/5.
    wr(0, 1, 10, w);
    a = w + 1;
    push_sched(0, a, 1, 10, 0, a + 40);
    wr(0, 5, 4, w2);
    chk("rej_numgtden_err", 32'(cfg_err), 32'(1));
    chk("rej_numgtden_pend", 32'(cfg_pending), 32'(0));
    @(negedge clk_sys);
    chk("rej_numgtden_err_clr", 32'(cfg_err), 32'(0));
    wr(0, 7, 0, w2);
    chk("rej_den0_err", 32'(cfg_err), 32'(1));
    chk("rej_den0_pend", 32'(cfg_pending), 32'(0));
    @(negedge clk_sys);
    chk("rej_den0_err_clr", 32'(cfg_err), 32'(0));
    wr(3, 1, 2, w2);
    chk("rej_badch_err", 32'(cfg_err), 32'(1));
    chk("rej_badch_pend", 32'(cfg_pending), 32'(0));
    @(negedge clk_sys);
    chk("rej_badch_err_clr", 32'(cfg_err), 32'(0));

    wait_to(a + 33);
    wr(0, 1, 5, w2);
    chk("retune_pend_set", 32'(cfg_pending), 32'(1));
    chk("retune_no_err", 32'(cfg_err), 32'(0));
    wait_to(a + 39);
    chk("retune_pend_hold", 32'(cfg_pending), 32'(1));
    push_sched(0, a + 40, 1, 5, a + 41, a + 140);
    wait_to(a + 40);
    chk("retune_pend_clr", 32'(cfg_pending), 32'(0));
    wait_to(a + 140);
    end_test("retune");

    // Pause ch2 (1/4) for 7 cycles with ch0 (1/3) running, then resync.
    wr(0, 1, 3, w);
    a0 = w + 1;
    wr(2, 1, 4, w);
    a2 = w + 1;
    r  = a2 + 29;
    push_sched(0, a0, 1, 3, 0, r - 1);
    push_sched(2, a2, 1, 4, 0, a2 + 10);
    push_sched(2, a2 + 7, 1, 4, a2 + 18, r - 1);
    wait_to(a2 + 10);
    pause = 3'b100;
    wait_to(a2 + 17);
    pause = 3'b000;
    wait_to(r - 3);
    wr(0, 1, 2, w);
    chk("resync_pend_before", 32'(cfg_pending), 32'(1));
    resync = 1'b1;
    pause  = 3'b111;
    @(negedge clk_sys);
    resync = 1'b0;
    pause  = 3'b000;
    chk("resync_pend_after", 32'(cfg_pending), 32'(0));
    push_sched(0, r, 1, 2, r + 1, r + 40);
    push_sched(2, r, 1, 4, r + 1, r + 40);
    wait_to(r + 40);
    end_test("resync");

`ifdef CE_GEN_PHASE_EN
    // 1/2 on ch0: ce and ce_n alternate, then reset mid-stream.
    wr(0, 1, 2, w);
    a = w + 1;
    push_sched(0, a, 1, 2, 0, a + 20);
    for (int k = 1; k <= 20; k++) begin
      wait_to(a + k);
      chk($sformatf("ce_n@%0d", cyc), 32'(ce_n[0]), 32'(k % 2));
    end
    end_test("phase");
    chk("phase_silent_ce_n", 32'(ce_n), 32'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
